// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: 50%-duty clk_out for any divisor 2..2^WIDTH-1,
// plus a per-period tick strobe, a wrapping period counter and a load/ack divisor handshake.
`timescale 1ns/1ps
module clk_div_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 5,
   parameter int PCNT_W      = 8
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              en,
   input  logic              sync_clr,
   input  logic [WIDTH-1:0]  div_in,
   input  logic              load,
   output logic              load_ack,
   output logic              load_err,
   output logic              busy,
   output logic [WIDTH-1:0]  div_cur,
   output logic              clk_out,
   output logic              tick,
   output logic [PCNT_W-1:0] period_cnt
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

   generate
      if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2**WIDTH - 1)) begin : g_bad_default
         $error("clk_div_prog: DEFAULT_DIV must lie in 2..2^WIDTH-1");
      end
   endgenerate

   logic [WIDTH-1:0]  div_cur_reg, div_cur_next;
   logic [WIDTH-1:0]  div_pend_reg, div_pend_next;
   logic              busy_reg, busy_next;
   logic [WIDTH-1:0]  cnt_reg, cnt_next;
   logic              pos_reg, pos_next;
   logic              neg_reg;
   logic              tick_reg, tick_next;
   logic              load_ack_reg, load_ack_next;
   logic              load_err_reg, load_err_next;
   logic [PCNT_W-1:0] period_cnt_reg, period_cnt_next;
   logic [WIDTH:0]    half_div;
   logic              load_ok;
   logic              last_cnt;
   logic              wrap;

   always_comb begin
      load_ok   = load && (div_in >= MIN_DIV);
      last_cnt  = (cnt_reg == (div_cur_reg - 1'b1));
      wrap      = en && (sync_clr || last_cnt);
      // One extra bit so div_cur = 2^WIDTH-1 cannot overflow.
      half_div  = ({1'b0, div_cur_reg} + 1'b1) >> 1;

      cnt_next        = cnt_reg;
      pos_next        = pos_reg;
      tick_next       = 1'b0;
      period_cnt_next = period_cnt_reg;
      div_cur_next    = div_cur_reg;
      div_pend_next   = div_pend_reg;
      busy_next       = busy_reg;
      load_ack_next   = 1'b0;
      load_err_next   = load && !load_ok;

      if (en) begin
         cnt_next  = wrap ? '0 : cnt_reg + 1'b1;
         pos_next  = ({1'b0, cnt_next} < half_div);
         tick_next = wrap;
         if (wrap) begin
            period_cnt_next = period_cnt_reg + 1'b1;
         end
      end

      // A valid load landing on the wrap edge supersedes anything pending.
      if (wrap) begin
         if (load_ok) begin
            div_cur_next  = div_in;
            busy_next     = 1'b0;
            load_ack_next = 1'b1;
         end else if (busy_reg) begin
            div_cur_next  = div_pend_reg;
            busy_next     = 1'b0;
            load_ack_next = 1'b1;
         end
      end else if (load_ok) begin
         div_pend_next = div_in;
         busy_next     = 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         div_cur_reg    <= DEF_DIV;
         div_pend_reg   <= '0;
         busy_reg       <= 1'b0;
         cnt_reg        <= DEF_DIV - 1'b1;
         pos_reg        <= 1'b0;
         tick_reg       <= 1'b0;
         load_ack_reg   <= 1'b0;
         load_err_reg   <= 1'b0;
         period_cnt_reg <= '0;
      end else begin
         div_cur_reg    <= div_cur_next;
         div_pend_reg   <= div_pend_next;
         busy_reg       <= busy_next;
         cnt_reg        <= cnt_next;
         pos_reg        <= pos_next;
         tick_reg       <= tick_next;
         load_ack_reg   <= load_ack_next;
         load_err_reg   <= load_err_next;
         period_cnt_reg <= period_cnt_next;
      end
   end

   // Half-cycle delayed copy of pos; ANDing it in trims odd-divisor high time by half a cycle.
   always_ff @(negedge clk_in or posedge rst) begin
      if (rst) begin
         neg_reg <= 1'b0;
      end else begin
         neg_reg <= pos_reg;
      end
   end

   assign clk_out    = div_cur_reg[0] ? (pos_reg & neg_reg) : pos_reg;
   assign tick       = tick_reg;
   assign load_ack   = load_ack_reg;
   assign load_err   = load_err_reg;
   assign busy       = busy_reg;
   assign div_cur    = div_cur_reg;
   assign period_cnt = period_cnt_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: table of divisor loads checked through a scoreboard
// queue, plus hand-written sequences for enable freeze, sync_clr, coincident loads and reset.
`timescale 1ns/1ps
module tb_clk_div_prog;

   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       sync_clr = 1'b0;
   logic       load = 1'b0;
   logic [7:0] div_in = 8'd0;
   logic       load_ack, load_err, busy, clk_out, tick;
   logic [7:0] div_cur, period_cnt;

   int n_checks = 0;
   int n_err = 0;
   int tick_model = 0;

   typedef struct {
      logic [7:0] div_in;
      bit         exp_err;
      logic [7:0] exp_div;
      int         exp_hi2;
      int         exp_lo2;
   } vec_t;

   vec_t vecs[8];
   vec_t sb_q[$];

   clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(5), .PCNT_W(8)) dut (
      .clk_in(clk_in), .rst(rst), .en(en), .sync_clr(sync_clr),
      .div_in(div_in), .load(load), .load_ack(load_ack), .load_err(load_err),
      .busy(busy), .div_cur(div_cur), .clk_out(clk_out), .tick(tick),
      .period_cnt(period_cnt)
   );

   initial forever #5 clk_in = ~clk_in;

   // Independent period counter: counts observed tick pulses.
   always @(posedge clk_in) begin
      #1;
      if (rst) tick_model = 0;
      else if (tick === 1'b1) tick_model = tick_model + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: timed out, got no event expected one", name);
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         step();
         n++;
      end while (tick !== 1'b1 && n < 600);
      if (tick !== 1'b1) timeout_fail("wait_tick");
   endtask

   task automatic count_to_tick(output int k);
      k = 0;
      do begin
         step();
         k++;
      end while (tick !== 1'b1 && k < 600);
   endtask

   // Counts half clk_in cycles until clk_out reaches lvl (sampled 1ns after each edge).
   task automatic wait_lvl(input logic lvl, output int n);
      n = 0;
      while (clk_out !== lvl && n < 1200) begin
         @(clk_in);
         #1;
         n++;
      end
      if (clk_out !== lvl) timeout_fail("clk_out level");
   endtask

   task automatic measure(output int hi2, output int lo2);
      int dummy;
      wait_lvl(1'b0, dummy);
      wait_lvl(1'b1, dummy);
      wait_lvl(1'b0, hi2);
      wait_lvl(1'b1, lo2);
   endtask

   task automatic wait_ack();
      int n = 0;
      while (load_ack !== 1'b1 && n < 600) begin
         step();
         n++;
      end
      if (load_ack !== 1'b1) timeout_fail("wait_ack");
   endtask

   initial begin
      int hi2, lo2, k, acks, bad;
      vec_t e;

      vecs[0] = '{8'd1,   1'b1, 8'd5,   5,   5};
      vecs[1] = '{8'd0,   1'b1, 8'd5,   5,   5};
      vecs[2] = '{8'd28,  1'b0, 8'd28,  28,  28};
      vecs[3] = '{8'd9,   1'b0, 8'd9,   9,   9};
      vecs[4] = '{8'd2,   1'b0, 8'd2,   2,   2};
      vecs[5] = '{8'd255, 1'b0, 8'd255, 255, 255};
      vecs[6] = '{8'd6,   1'b0, 8'd6,   6,   6};
      vecs[7] = '{8'd5,   1'b0, 8'd5,   5,   5};

      // Reset state
      #12;
      chk("rst_clk_out", clk_out, 0);
      chk("rst_tick", tick, 0);
      chk("rst_busy", busy, 0);
      chk("rst_load_ack", load_ack, 0);
      chk("rst_load_err", load_err, 0);
      chk("rst_div_cur", div_cur, 5);
      chk("rst_period_cnt", period_cnt, 0);
      @(negedge clk_in);
      rst = 1'b0;

      // First enabled edge wraps
      step();
      chk("first_tick", tick, 1);
      chk("first_pcnt", period_cnt, 1);
      count_to_tick(k);
      chk("default_period", k, 5);
      chk("second_pcnt", period_cnt, 2);
      measure(hi2, lo2);
      chk("default_hi2", hi2, 5);
      chk("default_lo2", lo2, 5);
      $display("txn reset-release: div_cur=%0d hi2=%0d lo2=%0d", div_cur, hi2, lo2);

      // Table of divisor loads, responses checked through the scoreboard
      for (int i = 0; i < 8; i++) begin
         wait_tick();
         load = 1'b1;
         div_in = vecs[i].div_in;
         sb_q.push_back(vecs[i]);
         step();
         load = 1'b0;
         e = sb_q.pop_front();
         chk("resp_err", load_err, e.exp_err);
         if (e.exp_err) begin
            chk("err_busy", busy, 0);
            chk("err_div_cur", div_cur, e.exp_div);
         end else begin
            chk("pend_busy", busy, 1);
            wait_ack();
            chk("ack_with_tick", tick, 1);
            chk("ack_div_cur", div_cur, e.exp_div);
            chk("ack_busy_clear", busy, 0);
            count_to_tick(k);
            chk("new_period", k, e.exp_div);
         end
         measure(hi2, lo2);
         chk("vec_hi2", hi2, e.exp_hi2);
         chk("vec_lo2", lo2, e.exp_lo2);
         $display("txn vec %0d: div_in=%0d err=%0d div_cur=%0d hi2=%0d lo2=%0d",
                  i, e.div_in, load_err, div_cur, hi2, lo2);
      end

      // Valid load coinciding with a wrap edge is applied directly
      wait_tick();
      repeat (4) step();
      load = 1'b1;
      div_in = 8'd6;
      step();
      load = 1'b0;
      chk("coinc_tick", tick, 1);
      chk("coinc_ack", load_ack, 1);
      chk("coinc_busy", busy, 0);
      chk("coinc_div_cur", div_cur, 6);
      $display("txn coincident load: div_cur=%0d", div_cur);

      // Two loads before the wrap: only the last one applies, one ack
      wait_tick();
      load = 1'b1;
      div_in = 8'd7;
      step();
      div_in = 8'd9;
      step();
      load = 1'b0;
      acks = 0;
      repeat (20) begin
         step();
         if (load_ack === 1'b1) acks++;
      end
      chk("double_load_acks", acks, 1);
      chk("double_load_div", div_cur, 9);
      measure(hi2, lo2);
      chk("div9_hi2", hi2, 9);
      chk("div9_lo2", lo2, 9);
      $display("txn double load: acks=%0d div_cur=%0d hi2=%0d lo2=%0d", acks, div_cur, hi2, lo2);

      // en low for 7 cycles while clk_out is high
      wait_tick();
      step();
      step();
      chk("pre_freeze_clk_out", clk_out, 1);
      en = 1'b0;
      bad = 0;
      repeat (7) begin
         step();
         if (clk_out !== 1'b1 || tick !== 1'b0) bad++;
      end
      chk("freeze_bad_cycles", bad, 0);
      chk("freeze_pcnt", period_cnt, tick_model % 256);
      en = 1'b1;
      count_to_tick(k);
      chk("freeze_remaining", k, 7);
      $display("txn en freeze: remaining=%0d", k);

      // sync_clr forces a wrap mid-period
      wait_tick();
      repeat (3) step();
      sync_clr = 1'b1;
      step();
      sync_clr = 1'b0;
      chk("sclr_tick", tick, 1);
      count_to_tick(k);
      chk("sclr_period", k, 9);
      $display("txn sync_clr: next period=%0d", k);

      // period_cnt wraps modulo 256
      wait_tick();
      load = 1'b1;
      div_in = 8'd2;
      step();
      load = 1'b0;
      wait_ack();
      repeat (560) step();
      chk("pcnt_track", period_cnt, tick_model % 256);
      chk("pcnt_wrapped", tick_model > 255, 1);
      $display("txn pcnt wrap: ticks=%0d period_cnt=%0d", tick_model, period_cnt);

      // Reset mid-period with 28 in effect and 12 pending
      wait_tick();
      load = 1'b1;
      div_in = 8'd28;
      step();
      load = 1'b0;
      wait_ack();
      repeat (3) step();
      chk("pre_rst_clk_out", clk_out, 1);
      load = 1'b1;
      div_in = 8'd12;
      step();
      load = 1'b0;
      chk("pre_rst_busy", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_clk_out", clk_out, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_div", div_cur, 5);
      chk("async_rst_pcnt", period_cnt, 0);
      @(negedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;
      step();
      chk("post_rst_tick", tick, 1);
      chk("post_rst_div", div_cur, 5);
      count_to_tick(k);
      chk("post_rst_period", k, 5);
      measure(hi2, lo2);
      chk("post_rst_hi2", hi2, 5);
      chk("post_rst_lo2", lo2, 5);
      $display("txn reset mid-period: div_cur=%0d period=%0d", div_cur, k);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
